// File: rtl/alu_pkg.sv
//==============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the ALU serial datapath
//               (lane select, 4-bit word).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_pkg;

  localparam int LANES = 4;

  typedef logic [1:0] lane_sel_t;
  typedef logic [3:0] word_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/deser4_if.sv
//==============================================================================
// Module      : deser4_if
// Description : Serial-in / word-out handshake bundle for deser4.
//               The master drives the serial input and consumes words;
//               the slave is the deserializer itself.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface deser4_if;
  import alu_pkg::*;

  logic      clr;
  logic      d;
  logic      d_valid;
  logic      d_ready;
  word_t     q;
  logic      q_valid;
  logic      q_ready;
  lane_sel_t sel;

  modport master (
    output clr, d, d_valid, q_ready,
    input  d_ready, q, q_valid, sel
  );

  modport slave (
    input  clr, d, d_valid, q_ready,
    output d_ready, q, q_valid, sel
  );

endinterface : deser4_if

`default_nettype wire

// File: rtl/deser4_demux4.sv
//==============================================================================
// Module      : demux4
// Description : Combinational 1:4 write-enable decoder. Exactly one output
//               is high when en is asserted, selected by sel.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module demux4
  import alu_pkg::*;
(
  input  wire logic      en,
  input  wire lane_sel_t sel,
  output logic [3:0]     z
);

  // One decoded enable per lane
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign z[i] = en && (sel == lane_sel_t'(i));
  end

endmodule : demux4

`default_nettype wire

// File: rtl/deser4.sv
//==============================================================================
// Module      : deser4
// Description : 4:1 serial-to-parallel deserializer. Accepted bits are steered
//               by a lane counter into an assembly register; completed words
//               are held in a valid/ready output register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module deser4
  import alu_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  deser4_if.slave   bus
);

  lane_sel_t r_cnt;
  word_t     r_a;
  word_t     r_q;
  logic      r_q_valid;

  lane_sel_t w_sel;
  logic      w_ready;
  logic      w_accept;
  logic      w_complete;
  logic      w_consume;
  logic [3:0] w_we;
  word_t     w_word;

  // Lane for the next accepted bit; MSB-first mode fills from lane 3 down
  assign w_sel = LSB_FIRST ? r_cnt : lane_sel_t'(2'd3 - r_cnt);

  // Only the completing bit can stall, and only while the held word is
  // still unconsumed; the q_ready term lets a consume and a completion
  // share the same cycle.
  assign w_ready    = !((r_cnt == 2'd3) && r_q_valid && !bus.q_ready);
  assign w_accept   = bus.d_valid && w_ready && !bus.clr;
  assign w_complete = w_accept && (r_cnt == 2'd3);
  assign w_consume  = r_q_valid && bus.q_ready;

  demux4 u_demux4 (
    .en  (w_accept),
    .sel (w_sel),
    .z   (w_we)
  );

  // Assembly word with the incoming bit merged into its lane; this is also
  // the value loaded into q on completion so the last bit is not lost.
  for (genvar i = 0; i < LANES; i++) begin : g_word
    assign w_word[i] = w_we[i] ? bus.d : r_a[i];
  end

  // Lane counter and assembly register; clr drops the partial word only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_a   <= '0;
    end else if (bus.clr) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= w_word;
      r_cnt <= (r_cnt == 2'd3) ? 2'd0 : r_cnt + 2'd1;
    end
  end

  // Output holding register with valid/ready handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else if (w_complete) begin
      r_q       <= w_word;
      r_q_valid <= 1'b1;
    end else if (w_consume) begin
      r_q_valid <= 1'b0;
    end
  end

  assign bus.d_ready = w_ready;
  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;
  assign bus.sel     = w_sel;

endmodule : deser4

`default_nettype wire

// File: tb/tb_deser4.sv
//==============================================================================
// Module      : tb_deser4
// Description : Self-checking bench for deser4. Drives an LSB-first and an
//               MSB-first instance with identical stimulus from a vector table
//               and checks each against hand-computed expectations.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_deser4;
  import alu_pkg::*;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       d;
    logic       dv;
    logic       qr;
    logic       chk;
    logic       e_dr;
    logic [3:0] e_q;
    logic       e_qv;
    logic [1:0] e_sel;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];

  deser4_if bus_l ();
  deser4_if bus_m ();

  // MSB-first instance sees the same stimulus as the LSB-first one
  assign bus_m.clr     = bus_l.clr;
  assign bus_m.d       = bus_l.d;
  assign bus_m.d_valid = bus_l.d_valid;
  assign bus_m.q_ready = bus_l.q_ready;

  deser4 #(.LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l.slave));
  deser4 #(.LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(bus_m.slave));

  always #5 clk = ~clk;

  function automatic logic [3:0] rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic d, input logic dv,
                     input logic qr, input logic chk, input logic e_dr,
                     input logic [3:0] e_q, input logic e_qv, input logic [1:0] e_sel);
    vec_t v;
    v.rst = r; v.clr = c; v.d = d; v.dv = dv; v.qr = qr; v.chk = chk;
    v.e_dr = e_dr; v.e_q = e_q; v.e_qv = e_qv; v.e_sel = e_sel;
    tbl.push_back(v);
  endtask

  task automatic check_both(input string tag, input logic e_dr, input logic [3:0] e_q,
                            input logic e_qv, input logic [1:0] e_sel);
    check({tag, " lsb d_ready"}, {3'b0, bus_l.d_ready}, {3'b0, e_dr});
    check({tag, " lsb q"},       bus_l.q,               e_q);
    check({tag, " lsb q_valid"}, {3'b0, bus_l.q_valid}, {3'b0, e_qv});
    check({tag, " lsb sel"},     {2'b0, bus_l.sel},     {2'b0, e_sel});
    check({tag, " msb d_ready"}, {3'b0, bus_m.d_ready}, {3'b0, e_dr});
    check({tag, " msb q"},       bus_m.q,               rev4(e_q));
    check({tag, " msb q_valid"}, {3'b0, bus_m.q_valid}, {3'b0, e_qv});
    check({tag, " msb sel"},     {2'b0, bus_m.sel},     2'd3 - {2'b0, e_sel});
  endtask

  initial begin
    logic [7:0] bits;
    int         waited;

    rst = 1'b1;
    bus_l.clr = 1'b0; bus_l.d = 1'b0; bus_l.d_valid = 1'b0; bus_l.q_ready = 1'b0;

    //   rst clr d dv qr chk | dr  q        qv sel
    // reset held two cycles with d_valid high
    add(1, 0, 1, 1, 0, 0,   1, 4'b0000, 0, 0);
    add(1, 0, 1, 1, 0, 1,   1, 4'b0000, 0, 0);
    // basic word 1,0,1,1 with q_ready high
    add(0, 0, 1, 1, 1, 1,   1, 4'b0000, 0, 0);
    add(0, 0, 0, 1, 1, 1,   1, 4'b0000, 0, 1);
    add(0, 0, 1, 1, 1, 1,   1, 4'b0000, 0, 2);
    add(0, 0, 1, 1, 1, 1,   1, 4'b0000, 0, 3);
    add(0, 0, 0, 0, 1, 1,   1, 4'b1101, 1, 0);
    add(0, 0, 0, 0, 0, 1,   1, 4'b1101, 0, 0);
    // backpressure: 1,1,1,1 then 0,1,0,0 with q_ready low
    add(0, 0, 1, 1, 0, 1,   1, 4'b1101, 0, 0);
    add(0, 0, 1, 1, 0, 1,   1, 4'b1101, 0, 1);
    add(0, 0, 1, 1, 0, 1,   1, 4'b1101, 0, 2);
    add(0, 0, 1, 1, 0, 1,   1, 4'b1101, 0, 3);
    add(0, 0, 0, 1, 0, 1,   1, 4'b1111, 1, 0);
    add(0, 0, 1, 1, 0, 1,   1, 4'b1111, 1, 1);
    add(0, 0, 0, 1, 0, 1,   1, 4'b1111, 1, 2);
    add(0, 0, 0, 1, 0, 1,   0, 4'b1111, 1, 3);
    add(0, 0, 0, 1, 0, 1,   0, 4'b1111, 1, 3);
    add(0, 0, 0, 1, 1, 1,   1, 4'b1111, 1, 3);
    add(0, 0, 0, 0, 0, 1,   1, 4'b0010, 1, 0);
    add(0, 0, 0, 0, 1, 1,   1, 4'b0010, 1, 0);
    // input gaps: valid 1,0,0,1,1,0,1 with bits 0,x,x,1,1,x,0
    add(0, 0, 0, 1, 1, 1,   1, 4'b0010, 0, 0);
    add(0, 0, 1, 0, 1, 1,   1, 4'b0010, 0, 1);
    add(0, 0, 1, 0, 1, 1,   1, 4'b0010, 0, 1);
    add(0, 0, 1, 1, 1, 1,   1, 4'b0010, 0, 1);
    add(0, 0, 1, 1, 1, 1,   1, 4'b0010, 0, 2);
    add(0, 0, 1, 0, 1, 1,   1, 4'b0010, 0, 3);
    add(0, 0, 0, 1, 1, 1,   1, 4'b0010, 0, 3);
    add(0, 0, 0, 0, 0, 1,   1, 4'b0110, 1, 0);
    add(0, 0, 0, 0, 1, 1,   1, 4'b0110, 1, 0);
    // build pending word 0101
    add(0, 0, 1, 1, 0, 1,   1, 4'b0110, 0, 0);
    add(0, 0, 0, 1, 0, 1,   1, 4'b0110, 0, 1);
    add(0, 0, 1, 1, 0, 1,   1, 4'b0110, 0, 2);
    add(0, 0, 0, 1, 0, 1,   1, 4'b0110, 0, 3);
    // abort: two bits, then clr together with a valid bit
    add(0, 0, 1, 1, 0, 1,   1, 4'b0101, 1, 0);
    add(0, 0, 1, 1, 0, 1,   1, 4'b0101, 1, 1);
    add(0, 1, 1, 1, 0, 1,   1, 4'b0101, 1, 2);
    add(0, 0, 0, 1, 0, 1,   1, 4'b0101, 1, 0);
    add(0, 0, 0, 1, 0, 1,   1, 4'b0101, 1, 1);
    add(0, 0, 1, 1, 0, 1,   1, 4'b0101, 1, 2);
    add(0, 0, 1, 1, 1, 1,   1, 4'b0101, 1, 3);
    add(0, 0, 0, 0, 0, 1,   1, 4'b1100, 1, 0);
    // reset mid-operation with q pending and two bits collected
    add(0, 0, 1, 1, 0, 1,   1, 4'b1100, 1, 0);
    add(0, 0, 1, 1, 0, 1,   1, 4'b1100, 1, 1);
    add(1, 0, 0, 0, 0, 1,   1, 4'b1100, 1, 2);
    add(0, 0, 1, 1, 1, 1,   1, 4'b0000, 0, 0);
    add(0, 0, 1, 1, 1, 1,   1, 4'b0000, 0, 1);
    add(0, 0, 0, 1, 1, 1,   1, 4'b0000, 0, 2);
    add(0, 0, 0, 1, 1, 1,   1, 4'b0000, 0, 3);
    add(0, 0, 0, 0, 1, 1,   1, 4'b0011, 1, 0);
    add(0, 0, 0, 0, 1, 1,   1, 4'b0011, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst           = tbl[i].rst;
      bus_l.clr     = tbl[i].clr;
      bus_l.d       = tbl[i].d;
      bus_l.d_valid = tbl[i].dv;
      bus_l.q_ready = tbl[i].qr;
      #1;
      if (tbl[i].chk)
        check_both($sformatf("vec%0d", i), tbl[i].e_dr, tbl[i].e_q, tbl[i].e_qv, tbl[i].e_sel);
    end

    // Back-to-back words with q_ready held high: no stall, no gap
    bits = 8'b0110_1001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_l.d = bits[i]; bus_l.d_valid = 1'b1; bus_l.q_ready = 1'b1;
      #1;
      check($sformatf("stream%0d d_ready", i), {3'b0, bus_l.d_ready}, 4'b0001);
      if (i == 4) check_both("stream word1", 1'b1, 4'b1001, 1'b1, 2'd0);
    end
    @(negedge clk);
    bus_l.d_valid = 1'b0; bus_l.q_ready = 1'b0;
    #1;
    check_both("stream word2", 1'b1, 4'b0110, 1'b1, 2'd0);

    // Word held until consumed, then valid drops within a bounded wait
    @(negedge clk);
    #1;
    check_both("hold", 1'b1, 4'b0110, 1'b1, 2'd0);
    bus_l.q_ready = 1'b1;
    waited = 0;
    while (bus_l.q_valid && waited < 5) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("consume within 1 cycle", waited[3:0], 4'd1);
    check_both("after consume", 1'b1, 4'b0110, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_deser4

`default_nettype wire
